hazard_ctrl: RTL

Pipeline hazard and stall controller for the four-lane 16-bit vector CPU. Generates the `stop` (freeze) and flush (bubble) controls for the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It handles three cases: multi-cycle load-use bubbles, variable-latency data-memory waits with timeout, and taken-branch squashes. It sits beside the decode stage and is the only driver of every pipeline register's `stop` input.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/sat_counter16.sv | 20 ++
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard controller state encoding and register index width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; counts every cycle en is high, clr wins over en.
module sat_counter16 (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    // Synchronous clear, otherwise count up until all ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= 16'd0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, data-memory waits with timeout, branch squash.
// Latency: stop/flush outputs are combinational (Mealy) from state and inputs, zero added cycles.
// Backpressure: a memory wait freezes all five pipeline registers; HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_regWrite,
    input  logic                 ex_resultSrc,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 stop_pc,
    output logic                 stop_ifid,
    output logic                 stop_idex,
    output logic                 stop_exmem,
    output logic                 stop_memwb,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 busy,
    output logic                 mem_timeout,
    output logic [15:0]          stall_cycles,
    output logic [15:0]          flush_events
);

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);
    localparam logic [7:0] TO_VAL  = 8'(MEM_TIMEOUT);

    hz_state_t  state, state_nxt, ret_state, ret_nxt, cur_state, eval_state;
    logic [2:0] lu_cnt, lu_cnt_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       timeout_set;
    logic       lu_hit;
    logic       mem_stall;

    assign lu_hit = ex_resultSrc & ex_regWrite & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign mem_stall = mem_req & ~mem_ready;

    // While reset is high the outputs behave as if in RUN, so a quiet pipeline sees all zeros.
    assign cur_state = reset ? RUN : state;
    assign busy      = (cur_state != RUN);

    // Next-state and output decode; a completed memory wait replays the interrupted state's behaviour.
    always_comb begin
        stop_pc      = 1'b0;
        stop_ifid    = 1'b0;
        stop_idex    = 1'b0;
        stop_exmem   = 1'b0;
        stop_memwb   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        state_nxt    = state;
        ret_nxt      = ret_state;
        lu_cnt_nxt   = lu_cnt;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        eval_state   = cur_state;

        if (cur_state == MEM_WAIT) begin
            if (!mem_ready) begin
                if (wait_cnt == TO_VAL) begin
                    // Give up: release the pipeline and drop any pending bubbles.
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                    lu_cnt_nxt  = 3'd0;
                end else begin
                    {stop_pc, stop_ifid, stop_idex, stop_exmem, stop_memwb} = 5'b11111;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end else begin
                eval_state = ret_state;
                state_nxt  = ret_state;
            end
        end

        case (eval_state)
            RUN: begin
                if (mem_stall) begin
                    {stop_pc, stop_ifid, stop_idex, stop_exmem, stop_memwb} = 5'b11111;
                    ret_nxt      = RUN;
                    wait_cnt_nxt = 8'd1;
                    state_nxt    = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    // The ID instruction is squashed, so any load-use hit on it is moot.
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    state_nxt  = RUN;
                end else if (lu_hit) begin
                    stop_pc    = 1'b1;
                    stop_ifid  = 1'b1;
                    flush_idex = 1'b1;
                    lu_cnt_nxt = LU_INIT;
                    state_nxt  = (LOAD_LAT == 1) ? RUN : LU_STALL;
                end else begin
                    state_nxt = RUN;
                end
            end
            LU_STALL: begin
                if (mem_stall) begin
                    {stop_pc, stop_ifid, stop_idex, stop_exmem, stop_memwb} = 5'b11111;
                    ret_nxt      = LU_STALL;
                    wait_cnt_nxt = 8'd1;
                    state_nxt    = MEM_WAIT;
                end else begin
                    stop_pc    = 1'b1;
                    stop_ifid  = 1'b1;
                    flush_idex = 1'b1;
                    lu_cnt_nxt = lu_cnt - 3'd1;
                    state_nxt  = (lu_cnt == 3'd1) ? RUN : LU_STALL;
                end
            end
            default: begin
            end
        endcase
    end

    // State, counters and the sticky timeout flag; reset abandons any stall in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            ret_state   <= RUN;
            lu_cnt      <= 3'd0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            lu_cnt    <= lu_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic any_stop;
    logic any_flush;

    assign any_stop  = stop_pc | stop_ifid | stop_idex | stop_exmem | stop_memwb;
    assign any_flush = flush_ifid | flush_idex;

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .en    (any_stop),
        .count (stall_cycles)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .en    (any_flush),
        .count (flush_events)
    );
`else
    assign stall_cycles = 16'd0;
    assign flush_events = 16'd0;
`endif

endmodule
